// File: rtl/matrix_dma_bridge.sv
// Bridges the matrix accelerator's single-word DMA port onto a Wishbone classic master.
// One transaction in flight; every bus cycle is bounded by a timeout and errors are sticky.
module matrix_dma_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cl_req_i,
  input  logic        cl_we_i,
  input  logic [31:0] cl_addr_i,
  input  logic [31:0] cl_wdata_i,
  output logic        cl_ack_o,
  output logic [31:0] cl_rdata_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  input  logic        err_clr_i,
  output logic [31:0] xfer_count_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrBus     = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;
  localparam logic [1:0] ErrAlign   = 2'b11;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [31:0]     count_q, count_d;

  logic            enter_resp;
  logic [1:0]      new_err;
  logic [31:0]     resp_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    code_d     = code_q;
    count_d    = count_q;
    enter_resp = 1'b0;
    new_err    = ErrNone;
    resp_data  = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (cl_req_i) begin
          if (cl_addr_i[1:0] != 2'b00) begin
            state_d    = StResp;
            enter_resp = 1'b1;
            new_err    = ErrAlign;
            resp_data  = cl_we_i ? 32'h0 : ERR_DATA;
          end else begin
            state_d = StBus;
            cyc_d   = 1'b1;
            we_d    = cl_we_i;
            adr_d   = cl_addr_i;
            dat_d   = cl_wdata_i;
            cnt_d   = '0;
          end
        end
      end
      StBus: begin
        cnt_d = cnt_q + CntW'(1);
        // Ack/err are checked before expiry so a response on the last cycle is honoured.
        if (m_err_i) begin
          enter_resp = 1'b1;
          new_err    = ErrBus;
          resp_data  = we_q ? 32'h0 : ERR_DATA;
        end else if (m_ack_i) begin
          enter_resp = 1'b1;
          resp_data  = we_q ? 32'h0 : m_dat_i;
        end else if (cnt_q == CntMax) begin
          enter_resp = 1'b1;
          new_err    = ErrTimeout;
          resp_data  = we_q ? 32'h0 : ERR_DATA;
        end
        if (enter_resp) begin
          state_d = StResp;
          cyc_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (enter_resp) begin
      rdata_d = resp_data;
      count_d = count_q + 32'd1;
    end

    // Clear wins over a same-edge error; otherwise only the first error is kept.
    if (err_clr_i) begin
      err_d  = 1'b0;
      code_d = ErrNone;
    end else if (new_err != ErrNone && !err_q) begin
      err_d  = 1'b1;
      code_d = new_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

  assign cl_ack_o     = (state_q == StResp);
  assign cl_rdata_o   = rdata_q;
  assign m_cyc_o      = cyc_q;
  assign m_stb_o      = cyc_q;
  assign m_we_o       = we_q;
  assign m_sel_o      = cyc_q ? 4'hF : 4'h0;
  assign m_adr_o      = adr_q;
  assign m_dat_o      = dat_q;
  assign busy_o       = (state_q != StIdle);
  assign err_o        = err_q;
  assign err_code_o   = code_q;
  assign xfer_count_o = count_q;

endmodule

// File: tb/tb_matrix_dma_bridge.sv
// Scoreboard bench for matrix_dma_bridge: directed scenarios plus randomized traffic
// against a transaction-level reference model of outcome, error stickiness and count.
module tb_matrix_dma_bridge;

  localparam int unsigned T       = 8;
  localparam logic [31:0] ErrData = 32'hDEADBEEF;
  localparam int          Never   = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cl_req_i, cl_we_i, err_clr_i;
  logic [31:0] cl_addr_i, cl_wdata_i;
  logic        cl_ack_o;
  logic [31:0] cl_rdata_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic        m_ack_i, m_err_i;
  logic        busy_o, err_o;
  logic [1:0]  err_code_o;
  logic [31:0] xfer_count_o;

  matrix_dma_bridge #(.TIMEOUT_CYCLES(T), .ERR_DATA(ErrData)) dut (
    .clk(clk), .reset(reset),
    .cl_req_i(cl_req_i), .cl_we_i(cl_we_i), .cl_addr_i(cl_addr_i), .cl_wdata_i(cl_wdata_i),
    .cl_ack_o(cl_ack_o), .cl_rdata_o(cl_rdata_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .m_err_i(m_err_i), .busy_o(busy_o), .err_o(err_o), .err_code_o(err_code_o),
    .err_clr_i(err_clr_i), .xfer_count_o(xfer_count_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; logic [1:0] code; logic [31:0] count; } exp_t;
  typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; } bus_t;
  typedef struct { int delay; logic err; logic [31:0] data; } slv_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  slv_t slv_q[$];

  int          checks = 0;
  int          errors = 0;
  int          model_count = 0;
  logic        model_err = 1'b0;
  logic [1:0]  model_code = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none (t=%0t)", name, $time);
  endtask

  // Slave: responds delay cycles into the strobe, per queued configuration.
  initial begin : slave
    slv_t cur;
    bit   active = 0;
    int   cnt = 0;
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    m_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (m_cyc_o && m_stb_o) begin
        if (!active) begin
          active = 1;
          cnt = 0;
          if (slv_q.size() == 0) begin
            flag("slave_cfg_missing");
            cur = '{delay: Never, err: 1'b0, data: 32'h0};
          end else cur = slv_q.pop_front();
        end else cnt++;
        m_dat_i = $urandom;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        if (cnt == cur.delay) begin
          if (cur.err) begin
            m_err_i = 1'b1;
            m_ack_i = 1'($urandom_range(0, 1));
          end else begin
            m_ack_i = 1'b1;
            m_dat_i = cur.data;
          end
        end
      end else begin
        active = 0;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
      end
    end
  end

  // Client-side monitor: every ack pulse pops one expected response.
  initial begin : ack_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (cl_ack_o) begin
        if (exp_q.size() == 0) flag("unexpected_ack");
        else begin
          e = exp_q.pop_front();
          check("rdata", cl_rdata_o, e.rdata);
          check("err_o", 32'(err_o), 32'(e.err));
          check("err_code", 32'(err_code_o), 32'(e.code));
          check("xfer_count", xfer_count_o, e.count);
        end
      end
    end
  end

  // Bus-side monitor: each new cycle must match the next expected bus access.
  initial begin : bus_mon
    bus_t b;
    logic prev_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (m_cyc_o && !prev_cyc) begin
        if (bus_q.size() == 0) flag("unexpected_bus_cycle");
        else begin
          b = bus_q.pop_front();
          check("m_adr", m_adr_o, b.adr);
          check("m_we", 32'(m_we_o), 32'(b.we));
          check("m_stb", 32'(m_stb_o), 32'd1);
          check("m_sel", 32'(m_sel_o), 32'hF);
          if (b.we) check("m_dat", m_dat_o, b.dat);
        end
      end
      prev_cyc = m_cyc_o;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the ack cycle.
  task automatic xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                      input int delay, input logic serr, input logic [31:0] sdata,
                      input logic clr);
    exp_t e;
    logic [1:0] code;
    int   n, lat;
    bit   mis = (addr[1:0] != 2'b00);
    if (mis) code = 2'b11;
    else if (delay >= int'(T)) code = 2'b10;
    else if (serr) code = 2'b01;
    else code = 2'b00;
    model_count++;
    if (clr) begin
      model_err = 1'b0;
      model_code = 2'b00;
    end else if (code != 2'b00 && !model_err) begin
      model_err = 1'b1;
      model_code = code;
    end
    e.rdata = we ? 32'h0 : (code != 2'b00 ? ErrData : sdata);
    e.err = model_err;
    e.code = model_code;
    e.count = 32'(model_count);
    exp_q.push_back(e);
    if (!mis) begin
      bus_q.push_back('{adr: addr, we: we, dat: wdata});
      slv_q.push_back('{delay: delay, err: serr, data: sdata});
    end
    lat = mis ? 2 : 3 + ((delay >= int'(T)) ? int'(T) - 1 : delay);
    cl_req_i = 1'b1;
    cl_we_i = we;
    cl_addr_i = addr;
    cl_wdata_i = wdata;
    err_clr_i = clr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cl_ack_o && n < 200);
    check("ack_latency", 32'(n), 32'(lat));
    @(posedge clk);
    #1;
    cl_req_i = 1'b0;
    err_clr_i = 1'b0;
  endtask

  task automatic clear_err();
    err_clr_i = 1'b1;
    @(posedge clk);
    #1;
    err_clr_i = 1'b0;
    model_err = 1'b0;
    model_code = 2'b00;
    @(negedge clk);
    check("clr_err_o", 32'(err_o), 32'd0);
    check("clr_err_code", 32'(err_code_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_delay();
    case ($urandom_range(0, 6))
      0: return 0;
      1: return 1;
      2: return 2;
      3: return int'(T) - 1;
      4: return int'(T);
      5: return Never;
      default: return 0;
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int wait_n;
    reset = 1'b1;
    cl_req_i = 1'b0;
    cl_we_i = 1'b0;
    cl_addr_i = 32'h0;
    cl_wdata_i = 32'h0;
    err_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ack", 32'(cl_ack_o), 32'd0);
    check("rst_cyc", 32'(m_cyc_o), 32'd0);
    check("rst_stb", 32'(m_stb_o), 32'd0);
    check("rst_sel", 32'(m_sel_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_code", 32'(err_code_o), 32'd0);
    check("rst_count", xfer_count_o, 32'd0);
    check("rst_rdata", cl_rdata_o, 32'd0);
    @(posedge clk);
    #1;

    xfer(32'h100, 1'b0, 32'h0, 2, 1'b0, 32'h12345678, 1'b0);
    xfer(32'h200, 1'b1, 32'hA5A5A5A5, 0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 64; i++)
      xfer(32'h1000 + 32'(4 * i), 1'b0, 32'h0, 0, 1'b0, $urandom, 1'b0);

    // Timeout, then a bus error that must not overwrite the first code.
    xfer(32'h300, 1'b0, 32'h0, Never, 1'b0, 32'h0, 1'b0);
    xfer(32'h304, 1'b1, 32'h11, 1, 1'b1, 32'h0, 1'b0);
    clear_err();

    // Misaligned access: no bus cycle, error 11.
    xfer(32'h102, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    clear_err();

    // Timeout boundary, and clear winning over a same-edge error.
    xfer(32'h400, 1'b0, 32'h0, int'(T) - 1, 1'b0, 32'hCAFEF00D, 1'b0);
    xfer(32'h404, 1'b0, 32'h0, int'(T), 1'b0, 32'h0, 1'b0);
    clear_err();
    xfer(32'h408, 1'b0, 32'h0, 1, 1'b1, 32'h0, 1'b1);

    // Reset in the middle of a bus cycle.
    bus_q.push_back('{adr: 32'h500, we: 1'b0, dat: 32'h0});
    slv_q.push_back('{delay: Never, err: 1'b0, data: 32'h0});
    cl_req_i = 1'b1;
    cl_we_i = 1'b0;
    cl_addr_i = 32'h500;
    repeat (3) @(negedge clk);
    check("cyc_before_reset", 32'(m_cyc_o), 32'd1);
    reset = 1'b1;
    cl_req_i = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_count = 0;
    model_err = 1'b0;
    model_code = 2'b00;
    @(negedge clk);
    check("reset_cyc", 32'(m_cyc_o), 32'd0);
    check("reset_count", xfer_count_o, 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    xfer(32'h600, 1'b0, 32'h0, 1, 1'b0, 32'h600D600D, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) clear_err();
      xfer(a, 1'($urandom_range(0, 1)), $urandom, pick_delay(),
           ($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 19) == 0));
    end

    wait_n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("final_count", xfer_count_o, 32'(model_count));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
